// File: rtl/pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl
//
// Central hazard and sequencing controller for the 5-stage RV32IM pipeline.
// It holds EX for multi-cycle M-extension ops, inserts load-use bubbles,
// squashes wrong-path instructions on taken branches/jumps, and selects
// operand forwarding sources for EX.
//
// Ports:
//   CLK, RESET            clock (rising edge), synchronous active-high reset
//   ID_RS1/RS2, ID_USES_* source registers of the instruction in ID
//   EX_RS1/RS2/RD         register fields of the instruction in EX
//   EX_MEMREAD            EX instruction is a load
//   EX_MDU_START          EX instruction is an M-extension op
//   EX_IS_DIV             1 = div/rem, 0 = mul (qualifies EX_MDU_START)
//   BRANCH_TAKEN          EX resolved a taken branch or jump
//   MEM_RD/MEM_REGWRITE   destination in EX/MEM
//   WB_RD/WB_REGWRITE     destination in MEM/WB
//   PC_STALL .. MDU_BUSY  pipeline stall/flush controls
//   FWD_A/FWD_B           00 ID/EX, 10 EX/MEM, 01 MEM/WB
//   DBG_STATE             current controller state (0 IDLE, 1 WAIT, 2 DONE)
//
// Stall/flush outputs are combinational from the current state and inputs,
// so the pipeline registers react at the same clock edge.
// ---------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
    parameter int MUL_STALLS = 1,
    parameter int DIV_STALLS = 33
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [4:0] ID_RS1,
    input  logic [4:0] ID_RS2,
    input  logic       ID_USES_RS1,
    input  logic       ID_USES_RS2,
    input  logic [4:0] EX_RS1,
    input  logic [4:0] EX_RS2,
    input  logic [4:0] EX_RD,
    input  logic       EX_MEMREAD,
    input  logic       EX_MDU_START,
    input  logic       EX_IS_DIV,
    input  logic       BRANCH_TAKEN,
    input  logic [4:0] MEM_RD,
    input  logic       MEM_REGWRITE,
    input  logic [4:0] WB_RD,
    input  logic       WB_REGWRITE,
    output logic       PC_STALL,
    output logic       IF_ID_STALL,
    output logic       IF_ID_FLUSH,
    output logic       ID_EX_STALL,
    output logic       ID_EX_FLUSH,
    output logic       EX_MEM_BUBBLE,
    output logic [1:0] FWD_A,
    output logic [1:0] FWD_B,
    output logic       MDU_BUSY,
    output logic [1:0] DBG_STATE
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_MDU_WAIT = 2'd1,
        S_MDU_DONE = 2'd2
    } state_t;

    localparam logic [5:0] MUL_N = 6'(MUL_STALLS);
    localparam logic [5:0] DIV_N = 6'(DIV_STALLS);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [5:0] r_count;
    logic [5:0] w_count_nxt;
    logic [5:0] w_mdu_n;
    logic       w_mdu_stall;
    logic       w_load_use;

    // State register
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= S_IDLE;
            r_count <= 6'd0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
        end
    end

    assign w_mdu_n = EX_IS_DIV ? DIV_N : MUL_N;

    // Next-state logic. The IDLE cycle that accepts the op is the first of
    // the N stall cycles, so the counter is loaded with N-1.
    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_mdu_stall = 1'b0;
        case (r_state)
            S_IDLE: begin
                // A branch alongside an MDU start is illegal; the branch wins.
                if (EX_MDU_START && !BRANCH_TAKEN) begin
                    w_mdu_stall = 1'b1;
                    if (w_mdu_n == 6'd1) begin
                        w_state_nxt = S_MDU_DONE;
                    end else begin
                        w_count_nxt = w_mdu_n - 6'd1;
                        w_state_nxt = S_MDU_WAIT;
                    end
                end
            end
            S_MDU_WAIT: begin
                w_mdu_stall = 1'b1;
                if (r_count == 6'd1) begin
                    w_state_nxt = S_MDU_DONE;
                end else begin
                    w_count_nxt = r_count - 6'd1;
                end
            end
            S_MDU_DONE: begin
                // EX_MDU_START ignored here so the finishing op does not
                // retrigger while it advances out of EX.
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_count_nxt = 6'd0;
            end
        endcase
    end

    assign w_load_use = EX_MEMREAD && (EX_RD != 5'd0) &&
                        ((ID_USES_RS1 && (ID_RS1 == EX_RD)) ||
                         (ID_USES_RS2 && (ID_RS2 == EX_RD)));

    function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
        if (MEM_REGWRITE && (MEM_RD != 5'd0) && (MEM_RD == rs))
            return 2'b10;
        else if (WB_REGWRITE && (WB_RD != 5'd0) && (WB_RD == rs))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    // Output priority: RESET > BRANCH_TAKEN > mdu_stall > load-use.
    always_comb begin
        PC_STALL      = 1'b0;
        IF_ID_STALL   = 1'b0;
        IF_ID_FLUSH   = 1'b0;
        ID_EX_STALL   = 1'b0;
        ID_EX_FLUSH   = 1'b0;
        EX_MEM_BUBBLE = 1'b0;
        MDU_BUSY      = 1'b0;
        FWD_A         = 2'b00;
        FWD_B         = 2'b00;
        DBG_STATE     = 2'b00;
        if (!RESET) begin
            FWD_A     = fwd_sel(EX_RS1);
            FWD_B     = fwd_sel(EX_RS2);
            DBG_STATE = r_state;
            if (BRANCH_TAKEN) begin
                // PC stays free so the redirect target loads.
                IF_ID_FLUSH = 1'b1;
                ID_EX_FLUSH = 1'b1;
            end else if (w_mdu_stall) begin
                PC_STALL      = 1'b1;
                IF_ID_STALL   = 1'b1;
                ID_EX_STALL   = 1'b1;
                EX_MEM_BUBBLE = 1'b1;
                MDU_BUSY      = 1'b1;
            end else if (w_load_use) begin
                PC_STALL    = 1'b1;
                IF_ID_STALL = 1'b1;
                ID_EX_FLUSH = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;

  localparam int MUL_N = 1;
  localparam int DIV_N = 33;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [4:0] ID_RS1, ID_RS2, EX_RS1, EX_RS2, EX_RD, MEM_RD, WB_RD;
  logic       ID_USES_RS1, ID_USES_RS2, EX_MEMREAD, EX_MDU_START, EX_IS_DIV;
  logic       BRANCH_TAKEN, MEM_REGWRITE, WB_REGWRITE;
  logic       PC_STALL, IF_ID_STALL, IF_ID_FLUSH, ID_EX_STALL, ID_EX_FLUSH;
  logic       EX_MEM_BUBBLE, MDU_BUSY;
  logic [1:0] FWD_A, FWD_B, DBG_STATE;

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en = 0;

  // clock / reset block
  always #5 CLK = ~CLK;

  pipeline_hazard_ctrl #(.MUL_STALLS(MUL_N), .DIV_STALLS(DIV_N)) dut (
    .CLK(CLK), .RESET(RESET),
    .ID_RS1(ID_RS1), .ID_RS2(ID_RS2),
    .ID_USES_RS1(ID_USES_RS1), .ID_USES_RS2(ID_USES_RS2),
    .EX_RS1(EX_RS1), .EX_RS2(EX_RS2), .EX_RD(EX_RD),
    .EX_MEMREAD(EX_MEMREAD), .EX_MDU_START(EX_MDU_START), .EX_IS_DIV(EX_IS_DIV),
    .BRANCH_TAKEN(BRANCH_TAKEN),
    .MEM_RD(MEM_RD), .MEM_REGWRITE(MEM_REGWRITE),
    .WB_RD(WB_RD), .WB_REGWRITE(WB_REGWRITE),
    .PC_STALL(PC_STALL), .IF_ID_STALL(IF_ID_STALL), .IF_ID_FLUSH(IF_ID_FLUSH),
    .ID_EX_STALL(ID_EX_STALL), .ID_EX_FLUSH(ID_EX_FLUSH),
    .EX_MEM_BUBBLE(EX_MEM_BUBBLE), .FWD_A(FWD_A), .FWD_B(FWD_B),
    .MDU_BUSY(MDU_BUSY), .DBG_STATE(DBG_STATE)
  );

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Tracks how many MDU stall cycles remain after the current one, and
  // whether the op has just finished (its one free cycle in EX).
  int m_left = 0;
  bit m_done = 0;

  always @(posedge CLK) begin
    if (RESET) begin
      m_left = 0;
      m_done = 0;
    end else if (m_left > 0) begin
      m_left = m_left - 1;
      if (m_left == 0) m_done = 1;
    end else if (m_done) begin
      m_done = 0;
    end else if (EX_MDU_START && !BRANCH_TAKEN) begin
      m_left = (EX_IS_DIV ? DIV_N : MUL_N) - 1;
      m_done = (m_left == 0);
    end
  end

  function automatic logic [1:0] m_fwd(input logic [4:0] rs);
    if (MEM_REGWRITE && MEM_RD != 0 && MEM_RD == rs) return 2'b10;
    if (WB_REGWRITE && WB_RD != 0 && WB_RD == rs) return 2'b01;
    return 2'b00;
  endfunction

  // scoreboard compare, every cycle at the falling edge
  always @(negedge CLK) begin
    logic mdu, lu;
    logic [6:0] ctl;
    logic [1:0] st;
    if (cmp_en) begin
      mdu = (m_left > 0) || (!m_done && EX_MDU_START);
      lu  = EX_MEMREAD && EX_RD != 0 &&
            ((ID_USES_RS1 && ID_RS1 == EX_RD) || (ID_USES_RS2 && ID_RS2 == EX_RD));
      // {PC_STALL, IF_ID_STALL, IF_ID_FLUSH, ID_EX_STALL, ID_EX_FLUSH, EX_MEM_BUBBLE, MDU_BUSY}
      if (RESET)             ctl = 7'b0000000;
      else if (BRANCH_TAKEN) ctl = 7'b0010100;
      else if (mdu)          ctl = 7'b1101011;
      else if (lu)           ctl = 7'b1100100;
      else                   ctl = 7'b0000000;
      st = RESET ? 2'd0 : (m_left > 0) ? 2'd1 : m_done ? 2'd2 : 2'd0;
      chk("ctl", {1'b0, PC_STALL, IF_ID_STALL, IF_ID_FLUSH, ID_EX_STALL,
                  ID_EX_FLUSH, EX_MEM_BUBBLE, MDU_BUSY}, {1'b0, ctl});
      chk("fwd_a", {6'd0, FWD_A}, RESET ? 8'd0 : {6'd0, m_fwd(EX_RS1)});
      chk("fwd_b", {6'd0, FWD_B}, RESET ? 8'd0 : {6'd0, m_fwd(EX_RS2)});
      chk("state", {6'd0, DBG_STATE}, {6'd0, st});
      chk("stall_flush_excl", {7'd0, ID_EX_STALL & ID_EX_FLUSH}, 8'd0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    ID_RS1 = 0; ID_RS2 = 0; ID_USES_RS1 = 0; ID_USES_RS2 = 0;
    EX_RS1 = 0; EX_RS2 = 0; EX_RD = 0; EX_MEMREAD = 0;
    EX_MDU_START = 0; EX_IS_DIV = 0; BRANCH_TAKEN = 0;
    MEM_RD = 0; MEM_REGWRITE = 0; WB_RD = 0; WB_REGWRITE = 0;
  endtask

  initial begin
    int busy;
    idle_inputs();
    RESET = 1;
    cmp_en = 1;

    // 1: reset with start, load-use and a forwarding match present
    EX_MDU_START = 1; EX_IS_DIV = 1; EX_MEMREAD = 1; EX_RD = 5;
    ID_RS1 = 5; ID_USES_RS1 = 1; EX_RS1 = 3; MEM_RD = 3; MEM_REGWRITE = 1;
    repeat (2) begin
      cyc();
      @(negedge CLK);
      chk("reset_ctl", {1'b0, PC_STALL, IF_ID_STALL, IF_ID_FLUSH, ID_EX_STALL,
                        ID_EX_FLUSH, EX_MEM_BUBBLE, MDU_BUSY}, 8'd0);
      chk("reset_fwd", {4'd0, FWD_A, FWD_B}, 8'd0);
    end
    cyc();
    idle_inputs();
    RESET = 0;
    @(negedge CLK);
    chk("post_reset_state", {6'd0, DBG_STATE}, 8'd0);

    // 2: DIV held for 33 cycles, forwarding active meanwhile
    cyc();
    EX_MDU_START = 1; EX_IS_DIV = 1;
    EX_RS1 = 9; MEM_RD = 9; MEM_REGWRITE = 1;
    EX_RS2 = 4; WB_RD = 4; WB_REGWRITE = 1;
    busy = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge CLK);
      if (!MDU_BUSY) break;
      busy++;
    end
    chk("div_stall_cycles", 8'(busy), 8'd33);
    chk("div_done_state", {6'd0, DBG_STATE}, 8'd2);
    chk("div_done_pc", {7'd0, PC_STALL}, 8'd0);
    cyc();
    EX_MDU_START = 0;
    @(negedge CLK);
    chk("div_back_idle", {6'd0, DBG_STATE}, 8'd0);

    // 3: MUL, then a back-to-back MUL
    cyc();
    idle_inputs();
    EX_MDU_START = 1;
    @(negedge CLK);
    chk("mul1_busy", {7'd0, MDU_BUSY}, 8'd1);
    cyc();
    @(negedge CLK);
    chk("mul1_done", {6'd0, DBG_STATE, MDU_BUSY}, 8'b100);
    cyc();
    @(negedge CLK);
    chk("mul2_busy", {7'd0, MDU_BUSY}, 8'd1);
    cyc();
    @(negedge CLK);
    chk("mul2_done", {7'd0, MDU_BUSY}, 8'd0);
    cyc();
    EX_MDU_START = 0;

    // 4: load-use on rs2, then same with rd = x0
    EX_MEMREAD = 1; EX_RD = 5; ID_RS2 = 5; ID_USES_RS2 = 1;
    @(negedge CLK);
    chk("lu_stall", {4'd0, PC_STALL, IF_ID_STALL, ID_EX_FLUSH, ID_EX_STALL}, 8'b1110);
    cyc();
    EX_RD = 0; ID_RS2 = 0;
    @(negedge CLK);
    chk("lu_x0", {6'd0, PC_STALL, ID_EX_FLUSH}, 8'd0);

    // 5: branch with load-use, then branch with MDU start
    cyc();
    EX_RD = 5; ID_RS2 = 5; BRANCH_TAKEN = 1;
    @(negedge CLK);
    chk("br_lu", {4'd0, IF_ID_FLUSH, ID_EX_FLUSH, PC_STALL, IF_ID_STALL}, 8'b1100);
    cyc();
    idle_inputs();
    BRANCH_TAKEN = 1; EX_MDU_START = 1; EX_IS_DIV = 1;
    @(negedge CLK);
    chk("br_mdu_busy", {7'd0, MDU_BUSY}, 8'd0);
    cyc();
    idle_inputs();
    @(negedge CLK);
    chk("br_mdu_idle", {6'd0, DBG_STATE}, 8'd0);

    // 6: forwarding priority and x0
    EX_RS1 = 7; MEM_RD = 7; MEM_REGWRITE = 1; WB_RD = 7; WB_REGWRITE = 1;
    EX_RS2 = 0;
    @(negedge CLK);
    chk("fwd_mem_wins", {4'd0, FWD_A, FWD_B}, 8'b1000);
    cyc();
    MEM_REGWRITE = 0;
    @(negedge CLK);
    chk("fwd_wb", {6'd0, FWD_A}, 8'b01);
    cyc();
    MEM_RD = 0; MEM_REGWRITE = 1; WB_RD = 0; EX_RS1 = 0;
    @(negedge CLK);
    chk("fwd_x0", {6'd0, FWD_A}, 8'b00);

    // 6: reset mid-DIV
    cyc();
    idle_inputs();
    EX_MDU_START = 1; EX_IS_DIV = 1;
    repeat (10) cyc();
    RESET = 1;
    @(negedge CLK);
    chk("mid_div_reset_busy", {7'd0, MDU_BUSY}, 8'd0);
    cyc();
    RESET = 0; EX_MDU_START = 0;
    @(negedge CLK);
    chk("mid_div_reset_idle", {6'd0, DBG_STATE, MDU_BUSY}, 8'd0);

    cyc();
    cyc();
    cmp_en = 0;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central hazard and sequencing controller for the 5-stage RV32IM pipeline. It drives stall/flush for the PC, IF/ID, ID/EX and EX/MEM registers, and operand-forwarding selects for EX.
It holds EX for multi-cycle M-extension ops (MUL/DIV), inserts load-use bubbles, and squashes wrong-path instructions on taken branches/jumps.
Stall and flush outputs are combinational from the current state and inputs, so pipeline registers react at the same clock edge.

Parameters:
MUL_STALLS, 1, EX stall cycles for MUL/MULH/MULHSU/MULHU (1..63)
DIV_STALLS, 33, EX stall cycles for DIV/DIVU/REM/REMU (1..63)

Ports:
CLK  in  1  clock, rising edge
RESET  in  1  synchronous, active-high reset
ID_RS1  in  5  rs1 of instruction in ID
ID_RS2  in  5  rs2 of instruction in ID
ID_USES_RS1  in  1  ID instruction reads rs1
ID_USES_RS2  in  1  ID instruction reads rs2
EX_RS1  in  5  rs1 of instruction in EX
EX_RS2  in  5  rs2 of instruction in EX
EX_RD  in  5  rd of instruction in EX
EX_MEMREAD  in  1  EX instruction is a load
EX_MDU_START  in  1  EX instruction is an M-extension op
EX_IS_DIV  in  1  qualifies EX_MDU_START: 1 = div/rem, 0 = mul
BRANCH_TAKEN  in  1  EX resolved a taken branch or JAL/JALR
MEM_RD  in  5  rd in EX/MEM
MEM_REGWRITE  in  1  EX/MEM writes the register file
WB_RD  in  5  rd in MEM/WB
WB_REGWRITE  in  1  MEM/WB writes the register file
PC_STALL  out  1  hold PC
IF_ID_STALL  out  1  hold IF/ID
IF_ID_FLUSH  out  1  zero IF/ID (NOP)
ID_EX_STALL  out  1  hold ID/EX
ID_EX_FLUSH  out  1  zero ID/EX control bits (bubble)
EX_MEM_BUBBLE  out  1  load a bubble into EX/MEM
FWD_A  out  2  EX operand A source: 00 ID/EX, 10 EX/MEM, 01 MEM/WB
FWD_B  out  2  same for operand B
MDU_BUSY  out  1  MDU stall active this cycle

Behaviour:
- Reset: RESET is synchronous and active-high, clock CLK. At the edge with RESET=1: state=IDLE, counter=0.
- While RESET=1, every output is forced to 0 combinationally.
- Reset during MDU_WAIT aborts the op; the controller is IDLE on the next cycle.
- FSM states: IDLE, MDU_WAIT, MDU_DONE. Counter is 6 bits.
- IDLE:
  - If EX_MDU_START=1 and BRANCH_TAKEN=0: N = DIV_STALLS if EX_IS_DIV else MUL_STALLS. mdu_stall=1 this cycle.
  - Next state: N==1 -> MDU_DONE; otherwise counter <= N-1 and next state MDU_WAIT.
- MDU_WAIT: mdu_stall=1. If counter==1 -> MDU_DONE; else counter decrements.
- Total stalled cycles = exactly N.
- MDU_DONE: mdu_stall=0 and EX_MDU_START is ignored, so the same op does not retrigger. The EX op advances. Next state IDLE.
- mdu_stall=1 outputs: PC_STALL=IF_ID_STALL=ID_EX_STALL=EX_MEM_BUBBLE=MDU_BUSY=1.
- Load-use hazard:
  - Condition: EX_MEMREAD & EX_RD!=0 & ((ID_USES_RS1 & ID_RS1==EX_RD) | (ID_USES_RS2 & ID_RS2==EX_RD)).
  - Response: PC_STALL=IF_ID_STALL=1, ID_EX_FLUSH=1. Costs exactly 1 bubble.
- BRANCH_TAKEN=1: IF_ID_FLUSH=1 and ID_EX_FLUSH=1. PC_STALL=0 so the redirect target loads.
- Priority, highest first: RESET > BRANCH_TAKEN > mdu_stall > load-use.
  - BRANCH_TAKEN together with EX_MDU_START in IDLE is illegal. Branch wins and the FSM stays IDLE.
  - Load-use is masked while mdu_stall=1. It re-evaluates in MDU_DONE.
  - ID_EX_FLUSH and ID_EX_STALL are never both 1.
- Forwarding (FWD_A uses EX_RS1, FWD_B uses EX_RS2):
  - Select 10 if MEM_REGWRITE & MEM_RD!=0 & MEM_RD==rs.
  - Else select 01 if WB_REGWRITE & WB_RD!=0 & WB_RD==rs.
  - Else 00.
  - EX/MEM wins when both match. x0 is never forwarded.
- Forwarding is valid in all FSM states; held operands re-forward each cycle.

Test Plan:
1. RESET=1 for 2 cycles with EX_MDU_START=1, EX_MEMREAD=1 -> all outputs 0. After release, state IDLE.
2. EX_MDU_START=1, EX_IS_DIV=1, DIV_STALLS=33 -> MDU_BUSY/PC_STALL high for exactly 33 cycles. Then 1 cycle low in MDU_DONE with EX_MDU_START still 1, with no retrigger.
3. MUL with MUL_STALLS=1 -> 1 stall cycle, MDU_DONE, IDLE. Back-to-back MUL entering EX after DONE -> stalls again for 1 cycle.
4. Load x5 in EX, ID reads rs2=x5 -> one cycle of PC_STALL=IF_ID_STALL=ID_EX_FLUSH=1. Repeat with rd=x0 -> no stall.
5. BRANCH_TAKEN=1 coincident with load-use -> IF_ID_FLUSH=ID_EX_FLUSH=1, PC_STALL=0.
6. EX_RS1=7 with MEM_RD=7/WB_RD=7 both writing -> FWD_A=10. MEM_REGWRITE=0 -> FWD_A=01. RESET asserted mid-DIV at cycle 10 -> IDLE, MDU_BUSY=0 next cycle.
